// File: rtl/calf_inject_ctrl_pkg.sv
// Shared flit layout for the CALF local injection port: field offsets and the
// helper that stamps a control field onto an accepted payload.
package calf_inject_ctrl_pkg;

    localparam int CTRL_W      = 144;
    localparam int FLIT_CTRL_W = 16;
    localparam int PAYLOAD_W   = CTRL_W - FLIT_CTRL_W;
    localparam int DST_LSB     = 0;
    localparam int SRC_LSB     = 4;
    localparam int SEQ_LSB     = 8;
    localparam int VALID_BIT   = 11;
    localparam int MSHR_LSB    = 12;
    localparam int PAYLOAD_LSB = FLIT_CTRL_W;
    localparam int SEQ_W       = 3;

    typedef logic [CTRL_W-1:0] flit_t;

    function automatic flit_t make_flit(
        input logic [PAYLOAD_W-1:0] payload,
        input logic [3:0]           mshr,
        input logic [SEQ_W-1:0]     seq,
        input logic [3:0]           src,
        input logic [3:0]           dst
    );
        flit_t f;
        f                              = '0;
        f[PAYLOAD_LSB +: PAYLOAD_W]    = payload;
        f[MSHR_LSB +: 4]               = mshr;
        f[VALID_BIT]                   = 1'b1;
        f[SEQ_LSB +: SEQ_W]            = seq;
        f[SRC_LSB +: 4]                = src;
        f[DST_LSB +: 4]                = dst;
        return f;
    endfunction

endpackage

// File: rtl/calf_inj_fifo.sv
// Injection FIFO for stamped flits; DEPTH must be a power of two (>= 2) so the
// pointers wrap naturally. Accepts a push while full only when a pop happens too.
module calf_inj_fifo
    import calf_inject_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  logic  pop,
    input  flit_t din,
    output flit_t head,
    output logic  full,
    output logic  empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;
    flit_t         mem_q [DEPTH];

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an empty count masks stale entries downstream.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/calf_inject_ctrl.sv
// Local-port injection controller: round-robin grant among requesters, control
// field stamping, FIFO toward the router, and an injection starvation flag.
module calf_inject_ctrl
    import calf_inject_ctrl_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             node_id,
    input  logic [NREQ-1:0]        req,
    input  logic [4*NREQ-1:0]      req_dst,
    input  logic [4*NREQ-1:0]      req_mshr,
    input  logic [128*NREQ-1:0]    req_data,
    output logic [NREQ-1:0]        gnt,
    output logic [CTRL_W-1:0]      port4_ci,
    input  logic                   port4_ready,
    input  logic                   port4_ack,
    output logic                   fifo_full,
    output logic                   starve,
    output logic [15:0]            inj_count
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int SW    = $clog2(STARVE_LIMIT + 1);

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [SW-1:0]    starve_cnt_q, starve_cnt_d;
    logic [15:0]      inj_count_q, inj_count_d;

    logic  fifo_empty;
    logic  pop, push, space, hit;
    int    sel, cand;
    flit_t fifo_head, push_flit;

    assign pop = ~fifo_empty & port4_ready & port4_ack;
    // Reset is folded in so no grant is ever shown while the block is held.
    assign space = rst & (~fifo_full | pop);

    always_comb begin
        gnt  = '0;
        sel  = 0;
        cand = 0;
        hit  = 1'b0;
        if (space) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = int'(rr_ptr_q) + k;
                if (cand >= NREQ) cand = cand - NREQ;
                if (!hit && req[cand]) begin
                    hit       = 1'b1;
                    sel       = cand;
                    gnt[cand] = 1'b1;
                end
            end
        end
    end

    assign push = hit;

    always_comb begin
        push_flit = make_flit(req_data[sel*PAYLOAD_W +: PAYLOAD_W],
                              req_mshr[sel*4 +: 4], seq_q, node_id,
                              req_dst[sel*4 +: 4]);

        rr_ptr_d = rr_ptr_q;
        if (hit) rr_ptr_d = (sel == NREQ-1) ? '0 : PTR_W'(sel + 1);

        seq_d = seq_q;
        if (push) seq_d = seq_q + 1'b1;

        inj_count_d = inj_count_q;
        if (pop) inj_count_d = inj_count_q + 16'd1;

        starve_cnt_d = starve_cnt_q;
        if (fifo_empty || pop)
            starve_cnt_d = '0;
        else if (starve_cnt_q != SW'(STARVE_LIMIT))
            starve_cnt_d = starve_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q     <= '0;
            seq_q        <= '0;
            starve_cnt_q <= '0;
            inj_count_q  <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            seq_q        <= seq_d;
            starve_cnt_q <= starve_cnt_d;
            inj_count_q  <= inj_count_d;
        end
    end

    calf_inj_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_flit),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign port4_ci  = fifo_empty ? '0 : fifo_head;
    assign starve    = (starve_cnt_q == SW'(STARVE_LIMIT));
    assign inj_count = inj_count_q;

endmodule

// File: tb/tb_calf_inject_ctrl.sv
// Directed bench for calf_inject_ctrl with hand-derived expected flits.
module tb_calf_inject_ctrl;

    localparam int NREQ = 4;

    logic               clk;
    logic               rst;
    logic [3:0]         node_id;
    logic [NREQ-1:0]    req;
    logic [4*NREQ-1:0]  req_dst;
    logic [4*NREQ-1:0]  req_mshr;
    logic [128*NREQ-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic [143:0]       port4_ci;
    logic               port4_ready;
    logic               port4_ack;
    logic               fifo_full;
    logic               starve;
    logic [15:0]        inj_count;

    int errs   = 0;
    int checks = 0;

    calf_inject_ctrl #(
        .NREQ         (NREQ),
        .DEPTH        (4),
        .STARVE_LIMIT (15)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .node_id     (node_id),
        .req         (req),
        .req_dst     (req_dst),
        .req_mshr    (req_mshr),
        .req_data    (req_data),
        .gnt         (gnt),
        .port4_ci    (port4_ci),
        .port4_ready (port4_ready),
        .port4_ack   (port4_ack),
        .fifo_full   (fifo_full),
        .starve      (starve),
        .inj_count   (inj_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester i: payload {4{C0DE_000i}}, mshr 1+i, dst 7+i; node 5.
    function automatic logic [143:0] exp_flit(input int i, input logic [2:0] seq);
        logic [127:0] p;
        p = {4{32'hC0DE_0000 + 32'(i)}};
        return {p, 4'(1 + i), 1'b1, seq, 4'h5, 4'(7 + i)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int          di [3];
    logic [2:0]  ds [3];

    initial begin
        di = '{2, 3, 1};
        ds = '{3'd2, 3'd3, 3'd4};
        rst         = 1'b0;
        req         = 4'hF;
        port4_ready = 1'b0;
        port4_ack   = 1'b0;
        node_id     = 4'h5;
        for (int i = 0; i < NREQ; i++) begin
            req_data[i*128 +: 128] = {4{32'hC0DE_0000 + 32'(i)}};
            req_mshr[i*4 +: 4]     = 4'(1 + i);
            req_dst[i*4 +: 4]      = 4'(7 + i);
        end

        // reset state with all requests high
        #12;
        check("rst_gnt",     144'(gnt), 144'h0);
        check("rst_ci",      port4_ci, 144'h0);
        check("rst_full",    144'(fifo_full), 144'h0);
        check("rst_starve",  144'(starve), 144'h0);
        check("rst_inj",     144'(inj_count), 144'h0);
        rst = 1'b1;
        #1;
        check("rr_first", 144'(gnt), 144'h1);
        req = 4'h0;

        // single flit, ack without ready ignored, then pop
        step();
        req = 4'b0001;
        #1;
        check("single_gnt", 144'(gnt), 144'h1);
        step();
        req = 4'h0;
        #1;
        check("single_ctrl", 144'(port4_ci[15:0]), 144'h1857);
        check("single_flit", port4_ci, exp_flit(0, 3'd0));
        port4_ack = 1'b1;
        step();
        check("ack_no_ready_ci",  port4_ci, exp_flit(0, 3'd0));
        check("ack_no_ready_inj", 144'(inj_count), 144'h0);
        port4_ready = 1'b1;
        step();
        check("single_pop_ci",  port4_ci, 144'h0);
        check("single_pop_inj", 144'(inj_count), 144'h1);
        port4_ready = 1'b0;
        port4_ack   = 1'b0;

        // async reset between edges, then round-robin fill
        rst = 1'b0;
        #2;
        rst = 1'b1;
        check("rst2_inj", 144'(inj_count), 144'h0);
        req = 4'hF;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("rr_gnt%0d", i), 144'(gnt), 144'(4'b0001 << i));
            @(posedge clk);
            #1;
        end
        check("fill_full", 144'(fifo_full), 144'h1);
        check("fill_gnt0", 144'(gnt), 144'h0);
        check("fill_head", port4_ci, exp_flit(0, 3'd0));

        // pop+push at full
        req         = 4'b0010;
        port4_ready = 1'b1;
        port4_ack   = 1'b1;
        #1;
        check("pp_gnt", 144'(gnt), 144'h2);
        step();
        req = 4'h0;
        #1;
        check("pp_full", 144'(fifo_full), 144'h1);
        check("pp_inj",  144'(inj_count), 144'h1);
        check("pp_head", port4_ci, exp_flit(1, 3'd1));
        for (int j = 0; j < 3; j++) begin
            step();
            check($sformatf("drain%0d", j), port4_ci, exp_flit(di[j], ds[j]));
        end
        step();
        check("drain_empty", port4_ci, 144'h0);
        check("drain_inj",   144'(inj_count), 144'h5);
        port4_ready = 1'b0;
        port4_ack   = 1'b0;

        // starvation: pointer now at 2, seq at 5
        req = 4'b0100;
        #1;
        check("st_gnt", 144'(gnt), 144'h4);
        step();
        req = 4'h0;
        #1;
        check("st_head",  port4_ci, exp_flit(2, 3'd5));
        check("st_init",  144'(starve), 144'h0);
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 14) check("st_14", 144'(starve), 144'h0);
            if (k == 15) check("st_15", 144'(starve), 144'h1);
            if (k == 16) check("st_sat", 144'(starve), 144'h1);
        end
        port4_ready = 1'b1;
        port4_ack   = 1'b1;
        step();
        check("st_clear", 144'(starve), 144'h0);
        check("st_inj",   144'(inj_count), 144'h6);
        port4_ready = 1'b0;
        port4_ack   = 1'b0;

        // async reset mid-run with a full FIFO (pointer at 3, seq at 6)
        req = 4'hF;
        for (int i = 0; i < 4; i++) step();
        req = 4'h0;
        #1;
        check("mr_full", 144'(fifo_full), 144'h1);
        check("mr_head", port4_ci, exp_flit(3, 3'd6));
        #1;
        rst = 1'b0;
        #1;
        check("mr_rst_ci",   port4_ci, 144'h0);
        check("mr_rst_full", 144'(fifo_full), 144'h0);
        check("mr_rst_inj",  144'(inj_count), 144'h0);
        rst = 1'b1;
        step();
        step();
        check("mr_no_stale", port4_ci, 144'h0);
        req = 4'b0001;
        #1;
        check("mr_gnt", 144'(gnt), 144'h1);
        step();
        req = 4'h0;
        #1;
        check("mr_fresh", port4_ci, exp_flit(0, 3'd0));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
